gray_code_counter: RTL



---
 rtl/gray_code_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/gray_code_counter.sv
// Gray-code engine: loadable up/down counter published in binary and Gray form,
// plus an independent registered binary<->Gray converter channel.
module gray_code_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] G,
   output logic             wrap,
   input  logic             in_valid,
   input  logic             dir,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;

   // Load beats counting; a load never reports a wrap.
   always_comb begin
      count_nxt = B;
      wrap_nxt  = 1'b0;
      if (load) begin
         count_nxt = gray2bin(load_gray);
      end else if (en) begin
         if (up_dn) begin
            count_nxt = B + ONE;
            wrap_nxt  = &B;
         end else begin
            count_nxt = B - ONE;
            wrap_nxt  = ~|B;
         end
      end
   end

   // B and G come from the same next value so they can never disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         B    <= '0;
         G    <= '0;
         wrap <= 1'b0;
      end else begin
         B    <= count_nxt;
         G    <= bin2gray(count_nxt);
         wrap <= wrap_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= dir ? gray2bin(in_data) : bin2gray(in_data);
         end
      end
   end

endmodule
